// File: rtl/seq_logic_unit_if.sv
// Request/response bundle for the multi-cycle bitwise logic unit.
// Master drives start/op/operands; slave returns busy/done/result/zero.
// No flow control beyond the start/busy/done handshake carried here.
interface seq_logic_unit_if #(
   parameter int WIDTH = 64
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             zero;

   modport master (
      output start, op, x, y,
      input  busy, done, result, zero
   );

   modport slave (
      input  start, op, x, y,
      output busy, done, result, zero
   );
endinterface

// File: rtl/seq_logic_unit.sv
// Multi-cycle AND/OR/XOR/XNOR unit, CHUNK bits per clock, with registered zero flag.
// Latency: done pulses WIDTH/CHUNK edges after the accept edge.
// Backpressure: start is ignored while busy; a start during the done cycle is accepted.
module seq_logic_unit #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input  logic          clk_i,
   input  logic          rst_i,
   seq_logic_unit_if.slave bus
);

   localparam int N    = WIDTH / CHUNK;
   localparam int IDXW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state_q,  state_d;
   logic [IDXW-1:0]  idx_q,    idx_d;
   logic [WIDTH-1:0] xa_q,     xa_d;
   logic [WIDTH-1:0] ya_q,     ya_d;
   logic [1:0]       op_q,     op_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             busy_q,   busy_d;
   logic             done_q,   done_d;
   logic             zero_q,   zero_d;

   // One slice of the selected bitwise operation; no carries cross slices.
   function automatic logic [CHUNK-1:0] slice_op(
      input logic [1:0]       op,
      input logic [CHUNK-1:0] a,
      input logic [CHUNK-1:0] b
   );
      logic [CHUNK-1:0] r;
      case (op)
         2'b00:   r = a & b;
         2'b01:   r = a | b;
         2'b10:   r = a ^ b;
         default: r = ~(a ^ b);
      endcase
      return r;
   endfunction

   // State register; reset discards any operation in flight.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         xa_q     <= '0;
         ya_q     <= '0;
         op_q     <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         xa_q     <= xa_d;
         ya_q     <= ya_d;
         op_q     <= op_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         zero_q   <= zero_d;
      end
   end

   // Next state: accept in IDLE, then fill one result slice per cycle in RUN.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      xa_d     = xa_q;
      ya_d     = ya_q;
      op_d     = op_q;
      result_d = result_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      zero_d   = zero_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               xa_d     = bus.x;
               ya_d     = bus.y;
               op_d     = bus.op;
               result_d = '0;
               idx_d    = '0;
               busy_d   = 1'b1;
               state_d  = RUN;
            end
         end
         RUN: begin
            result_d[idx_q*CHUNK +: CHUNK] = slice_op(op_q,
                                                      xa_q[idx_q*CHUNK +: CHUNK],
                                                      ya_q[idx_q*CHUNK +: CHUNK]);
            if (idx_q == LAST_IDX) begin
               // zero is taken from the completed word, including this final slice.
               busy_d  = 1'b0;
               done_d  = 1'b1;
               zero_d  = (result_d == '0);
               idx_d   = '0;
               state_d = IDLE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.zero   = zero_q;

endmodule

// File: tb/tb_seq_logic_unit.sv
// Self-checking bench for seq_logic_unit: directed scenarios plus randomized ops.
// Expected values come from a word-level reference of the four bitwise ops.
// Inputs are driven #1 after the rising edge; outputs are sampled at the same point.
module tb_seq_logic_unit;

   localparam int WIDTH = 64;
   localparam int CHUNK = 16;
   localparam int N     = WIDTH / CHUNK;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   seq_logic_unit_if #(.WIDTH(WIDTH)) lu ();

   seq_logic_unit #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (lu)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Word-level reference of the operation.
   function automatic logic [63:0] ref_op(input logic [1:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
      case (op)
         2'b00:   return a & b;
         2'b01:   return a | b;
         2'b10:   return a ^ b;
         default: return ~(a ^ b);
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs one operation. When chain_in is set the inputs are already on the bus.
   // disturb keeps start high with junk operands while busy; chain_out presents
   // the next operation during the done cycle.
   task automatic do_op(input string tag, input logic [1:0] op, input logic [63:0] a,
                        input logic [63:0] b, input bit disturb, input bit chain_in,
                        input bit chain_out, input logic [1:0] nop,
                        input logic [63:0] na, input logic [63:0] nb);
      logic [63:0] exp;
      logic [63:0] mask;
      bit          got_done;
      int          lat;
      exp = ref_op(op, a, b);
      if (!chain_in) begin
         lu.start = 1'b1;
         lu.op    = op;
         lu.x     = a;
         lu.y     = b;
      end
      step();  // accept edge
      chk({tag, " busy@accept"}, 64'(lu.busy), 64'd1);
      chk({tag, " done@accept"}, 64'(lu.done), 64'd0);
      chk({tag, " result cleared"}, lu.result, 64'd0);
      lu.start = disturb;
      lu.op    = 2'($urandom);
      lu.x     = {$urandom, $urandom};
      lu.y     = {$urandom, $urandom};
      got_done = 1'b0;
      lat      = 0;
      for (int k = 1; k <= N + 4 && !got_done; k++) begin
         step();
         if (lu.done) begin
            got_done = 1'b1;
            lat      = k;
            lu.start = chain_out;
            if (chain_out) begin
               lu.op = nop;
               lu.x  = na;
               lu.y  = nb;
            end
         end else if (k < N) begin
            mask = (64'd1 << (k * CHUNK)) - 64'd1;
            chk({tag, " busy mid"}, 64'(lu.busy), 64'd1);
            chk({tag, " partial"}, lu.result, exp & mask);
         end
      end
      chk({tag, " done seen"}, 64'(got_done), 64'd1);
      if (got_done) begin
         chk({tag, " latency"}, 64'(lat), 64'(N));
         chk({tag, " result"}, lu.result, exp);
         chk({tag, " zero"}, 64'(lu.zero), 64'(exp == 64'd0));
         chk({tag, " busy@done"}, 64'(lu.busy), 64'd0);
         if (!chain_out) begin
            step();
            chk({tag, " done drop"}, 64'(lu.done), 64'd0);
            chk({tag, " result hold"}, lu.result, exp);
            chk({tag, " zero hold"}, 64'(lu.zero), 64'(exp == 64'd0));
         end
      end
   endtask

   initial begin
      logic [1:0]  cop, nop;
      logic [63:0] ca, cb, na, nb;
      bit          cin, cout;
      bit          stray_done;

      n_checks = 0;
      n_errors = 0;
      rst      = 1'b1;
      lu.start = 1'b0;
      lu.op    = 2'b00;
      lu.x     = '0;
      lu.y     = '0;
      step();
      step();
      chk("reset busy", 64'(lu.busy), 64'd0);
      chk("reset done", 64'(lu.done), 64'd0);
      chk("reset zero", 64'(lu.zero), 64'd0);
      chk("reset result", lu.result, 64'd0);
      rst = 1'b0;
      step();

      // Directed scenarios.
      do_op("xor0", 2'b10, 64'd0, 64'd0, 0, 0, 0, 2'b00, 64'd0, 64'd0);
      do_op("xor1", 2'b10, 64'd1, 64'd1, 0, 0, 0, 2'b00, 64'd0, 64'd0);
      do_op("xorF", 2'b10, '1, '1, 0, 0, 0, 2'b00, 64'd0, 64'd0);
      do_op("xorv", 2'b10, 64'h13345678_4ACBCF77, 64'hFEECB209_8755D301, 0, 0, 0,
            2'b00, 64'd0, 64'd0);
      chk("xor vec const", lu.result, 64'hEDD8E471_CD9E1C76);
      do_op("xnorv", 2'b11, 64'h13345678_4ACBCF77, 64'hFEECB209_8755D301, 0, 0, 0,
            2'b00, 64'd0, 64'd0);
      chk("xnor vec const", lu.result, 64'h12271B8E_3261E389);
      do_op("or", 2'b01, 64'hF0F0F0F0_F0F0F0F0, 64'h0F0F0F0F_0F0F0F0F, 0, 0, 1,
            2'b00, 64'hF0F0F0F0_F0F0F0F0, 64'h0F0F0F0F_0F0F0F0F);
      do_op("and b2b", 2'b00, 64'hF0F0F0F0_F0F0F0F0, 64'h0F0F0F0F_0F0F0F0F, 0, 1, 0,
            2'b00, 64'd0, 64'd0);
      do_op("busy start", 2'b01, 64'h0123_4567_89AB_CDEF, 64'h1111_0000_2222_0000, 1, 0, 0,
            2'b00, 64'd0, 64'd0);

      // Reset at the second edge of an operation.
      lu.start = 1'b1;
      lu.op    = 2'b01;
      lu.x     = 64'hDEAD_BEEF_0000_FFFF;
      lu.y     = 64'h1;
      step();
      lu.start = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst busy", 64'(lu.busy), 64'd0);
      chk("rst done", 64'(lu.done), 64'd0);
      chk("rst result", lu.result, 64'd0);
      chk("rst zero", 64'(lu.zero), 64'd0);
      stray_done = 1'b0;
      for (int k = 0; k < N + 2; k++) begin
         step();
         if (lu.done) stray_done = 1'b1;
      end
      chk("rst no done", 64'(stray_done), 64'd0);
      do_op("post rst", 2'b10, 64'hAAAA_5555_AAAA_5555, 64'hFFFF_0000_FFFF_0000, 0, 0, 0,
            2'b00, 64'd0, 64'd0);

      // Randomized ops, with random busy-time starts and back-to-back chaining.
      cop = 2'($urandom);
      ca  = {$urandom, $urandom};
      cb  = {$urandom, $urandom};
      cin = 1'b0;
      for (int i = 0; i < 40; i++) begin
         nop  = 2'($urandom);
         na   = {$urandom, $urandom};
         case ($urandom_range(0, 3))
            0:       nb = na;
            1:       nb = ~na;
            default: nb = {$urandom, $urandom};
         endcase
         cout = (i != 39) && ($urandom_range(0, 1) == 1);
         do_op("rand", cop, ca, cb, bit'($urandom_range(0, 1)), cin, cout, nop, na, nb);
         cin = cout;
         cop = nop;
         ca  = na;
         cb  = nb;
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
